// File: rtl/histo_pkg.sv
// histo_pkg: shared constants, FSM encoding and the lane-collision helper for histo_memory.
package histo_pkg;

  localparam int unsigned LANES_DEF  = 8;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 256;

  // Upper bounds for the width-agnostic collision helper below.
  localparam int unsigned MAX_LANES  = 32;
  localparam int unsigned MAX_ADDR_W = 32;
  localparam int unsigned MATCH_W    = $clog2(MAX_LANES + 1);

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t DRAIN = 2'd1;
  localparam state_t CLEAR = 2'd2;

  typedef logic [MAX_ADDR_W-1:0] addr_arr_t [MAX_LANES];

  // Number of enabled lanes sharing lane i's address (0 when lane i is disabled).
  function automatic logic [MATCH_W-1:0] lane_match_count(
    input logic [MAX_LANES-1:0] mask,
    input addr_arr_t            addrs,
    input int                   i
  );
    logic [MATCH_W-1:0] n;
    n = '0;
    if (mask[i]) begin
      for (int j = 0; j < int'(MAX_LANES); j++) begin
        if (mask[j] && (addrs[j] == addrs[i])) n = n + MATCH_W'(1);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/histo_lane_merge.sv
// histo_lane_merge: combinational collision merge. Each address group is written
// once, by its lowest-index enabled lane, carrying the group's hit count.
module histo_lane_merge
  import histo_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CNT_W  = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]        mask,
  input  logic [LANES*ADDR_W-1:0] addr,
  output logic [LANES-1:0]        wr_en,
  output logic [LANES*CNT_W-1:0]  wr_cnt
);

  logic [MAX_LANES-1:0] eff_mask;
  addr_arr_t            addr_x;
  logic                 lead;

  // Out-of-range addresses behave as masked lanes.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
  endfunction

  // Widen lanes into the helper's fixed-size view; unused lanes stay disabled.
  always_comb begin
    eff_mask = '0;
    for (int i = 0; i < int'(MAX_LANES); i++) addr_x[i] = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      addr_x[i]   = MAX_ADDR_W'(addr[i*ADDR_W +: ADDR_W]);
      eff_mask[i] = mask[i] && addr_ok(addr[i*ADDR_W +: ADDR_W]);
    end
  end

  // Leader election and per-group counts.
  always_comb begin
    wr_en  = '0;
    wr_cnt = '0;
    lead   = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      lead = eff_mask[i];
      for (int j = 0; j < i; j++) begin
        if (eff_mask[j] && (addr_x[j] == addr_x[i])) lead = 1'b0;
      end
      wr_en[i]                  = lead;
      wr_cnt[i*CNT_W +: CNT_W]  = CNT_W'(lane_match_count(eff_mask, addr_x, i));
    end
  end

endmodule

// File: rtl/histo_memory.sv
// histo_memory: multi-lane histogram counter RAM with merged collisions,
// registered multi-port read-back and a hardware clear sequencer.
// Build option: define HISTO_SAT_EN for saturating counters and a sticky sat_flag;
// otherwise counters wrap and sat_flag is tied low.
module histo_memory
  import histo_pkg::*;
#(
  parameter  int unsigned LANES  = LANES_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_mask,
  input  logic [LANES*ADDR_W-1:0] in_addr,
  input  logic [LANES*ADDR_W-1:0] rd_addr,
  output logic [LANES*DATA_W-1:0] rd_data,
  input  logic                    clear_start,
  output logic                    busy,
  output logic                    clear_done,
  output logic                    sat_flag
);

  localparam int unsigned     CNT_W  = $clog2(LANES + 1);
  localparam logic [ADDR_W-1:0] K_STEP = ADDR_W'(LANES);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(DEPTH - LANES);

  logic [DATA_W-1:0]       mem [DEPTH];

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       k_q, k_d;
  logic                    accept;

  logic                    s1_valid_q;
  logic [LANES-1:0]        s1_mask_q;
  logic [LANES*ADDR_W-1:0] s1_addr_q;

  logic [LANES-1:0]        wr_en;
  logic [LANES*CNT_W-1:0]  wr_cnt;
  logic [ADDR_W-1:0]       lane_addr  [LANES];
  logic [DATA_W-1:0]       lane_wdata [LANES];
`ifdef HISTO_SAT_EN
  logic [DATA_W:0]         lane_sum   [LANES];
  logic [LANES-1:0]        sat_hit;
`endif

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
  endfunction

  assign accept = in_valid && in_ready;

  // FSM state and clear index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state: IDLE -> DRAIN on clear_start, one DRAIN cycle, then sweep LANES bins per cycle.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE:    if (clear_start) state_d = DRAIN;
      DRAIN:   state_d = CLEAR;
      CLEAR: begin
        if (k_q == K_LAST) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + K_STEP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      in_ready   <= (state_d == IDLE);
      busy       <= (state_d != IDLE);
      clear_done <= (state_d == CLEAR) && (k_d == K_LAST);
    end
  end

  // Stage-1 valid.
  always_ff @(posedge clk) begin
    if (reset) s1_valid_q <= 1'b0;
    else       s1_valid_q <= accept;
  end

  // Stage-1 payload, loaded only on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_mask_q <= in_mask;
      s1_addr_q <= in_addr;
    end
  end

  histo_lane_merge #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_merge (
    .mask   (s1_mask_q),
    .addr   (s1_addr_q),
    .wr_en  (wr_en),
    .wr_cnt (wr_cnt)
  );

  // Stage-2 read-modify-write data per lane.
  always_comb begin
`ifdef HISTO_SAT_EN
    sat_hit = '0;
`endif
    for (int i = 0; i < int'(LANES); i++) begin
      lane_addr[i] = s1_addr_q[i*ADDR_W +: ADDR_W];
`ifdef HISTO_SAT_EN
      lane_sum[i]   = {1'b0, mem[lane_addr[i]]} + (DATA_W + 1)'(wr_cnt[i*CNT_W +: CNT_W]);
      sat_hit[i]    = wr_en[i] & lane_sum[i][DATA_W];
      lane_wdata[i] = lane_sum[i][DATA_W] ? '1 : lane_sum[i][DATA_W-1:0];
`else
      lane_wdata[i] = mem[lane_addr[i]] + DATA_W'(wr_cnt[i*CNT_W +: CNT_W]);
`endif
    end
  end

  // RAM writes: clear sweep or merged increments; reset blocks any write that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        for (int i = 0; i < int'(LANES); i++) mem[k_q + ADDR_W'(i)] <= '0;
      end else if (s1_valid_q) begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (wr_en[i]) mem[lane_addr[i]] <= lane_wdata[i];
        end
      end
    end
  end

  // Registered read-back, read-before-write; out-of-range lanes return zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      for (int i = 0; i < int'(LANES); i++) begin
        rd_data[i*DATA_W +: DATA_W] <= addr_ok(rd_addr[i*ADDR_W +: ADDR_W])
                                       ? mem[rd_addr[i*ADDR_W +: ADDR_W]] : '0;
      end
    end
  end

`ifdef HISTO_SAT_EN
  // Sticky saturation flag, dropped when a clear sweep completes.
  always_ff @(posedge clk) begin
    if (reset)                                      sat_flag <= 1'b0;
    else if ((state_q == CLEAR) && (state_d == IDLE)) sat_flag <= 1'b0;
    else if (s1_valid_q && (|sat_hit))              sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: doc/histo_memory.md
Name: histo_memory

Overview:
- Parametrised multi-lane histogram memory: each accepted beat increments up to LANES bins in a DEPTH-entry counter RAM.
- Same-cycle lane collisions are merged, so a bin hit by k lanes gains exactly k.
- Provides a registered multi-port read-back and a hardware clear sequencer.
- Sits behind the vector datapath as the successor of the fixed 8-lane, 16-bit counter memory.

Parameters:
LANES, 8, number of address lanes per beat
DATA_W, 16, counter width in bits
DEPTH, 256, number of bins; must be a multiple of LANES
ADDR_W, $clog2(DEPTH), bin address width (derived, not overridden)

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high
in_valid  in  1  increment beat offered
in_ready  out  1  beat accepted when in_valid && in_ready
in_mask  in  LANES  per-lane enable; lane i counts only if in_mask[i]
in_addr  in  LANES*ADDR_W  lane i bin address at [i*ADDR_W +: ADDR_W]
rd_addr  in  LANES*ADDR_W  read-back addresses, lane-packed as in_addr
rd_data  out  LANES*DATA_W  registered counter values, lane-packed
clear_start  in  1  request zeroing of all bins; sampled only in IDLE
busy  out  1  high in DRAIN and CLEAR
clear_done  out  1  one-cycle pulse on the last CLEAR cycle
sat_flag  out  1  sticky saturation indicator (see Optional Feature)

Behaviour:
- Reset values:
  - in_ready=0 during the reset cycle, then 1 in IDLE.
  - busy=0, clear_done=0, sat_flag=0, rd_data=0.
  - FSM=IDLE; stage-1 valid cleared.
  - RAM contents are not touched by reset; RAM powers up zero.
- Pipeline:
  - Stage 1 registers in_mask, in_addr and valid on acceptance at edge N.
  - Stage 2 is combinational from the stage-1 registers and writes RAM at edge N+1.
  - Write latency is therefore 1 cycle after acceptance.
  - Throughput is one beat per cycle; there is no RAM hazard because each bin's read-modify-write completes within stage 2.
- Collision merge (stage 2):
  - For each enabled lane i, cnt_i = number of enabled lanes j with addr_j == addr_i.
  - Only the lowest-index enabled lane of each address group writes: RAM[addr] <= RAM[addr] + cnt.
  - Arithmetic is performed at DATA_W+1 bits, then resolved per Optional Feature.
- Address range: lanes with addr >= DEPTH are treated as masked (relevant only for non-power-of-two DEPTH).
- Read port:
  - rd_data lane i <= RAM[rd_addr_i] at every posedge (1-cycle latency), in all states.
  - Read-before-write: a same-edge update is not visible until the next read.
  - An out-of-range rd_addr returns 0.
- FSM states:
  - IDLE: in_ready=1. clear_start -> DRAIN. A beat accepted in that same cycle is still counted.
  - DRAIN: one cycle; in_ready=0; the pending stage-1 beat retires -> CLEAR.
  - CLEAR:
    - in_ready=0.
    - Index k starts at 0; the cycle writes zero to bins k..k+LANES-1, then k += LANES.
    - When k+LANES == DEPTH: pulse clear_done, reset k to 0 -> IDLE.
    - Duration is DEPTH/LANES cycles.
- clear_start outside IDLE is ignored. sat_flag is also cleared on the CLEAR->IDLE transition.
- Reset mid-DRAIN/CLEAR: abort to IDLE; RAM is left partially cleared; the stage-1 beat is dropped.
- Handshake: in_valid is honoured only with in_ready; in_mask=0 beats are accepted and have no effect.

Optional Feature:
- Macro HISTO_SAT_EN.
- Defined:
  - A sum exceeding 2^DATA_W-1 writes 2^DATA_W-1.
  - sat_flag is set and stays set until reset or clear completion.
- Undefined:
  - Sums wrap modulo 2^DATA_W.
  - sat_flag is tied 0.

Decomposition:
- Package histo_pkg:
  - state enum (IDLE, DRAIN, CLEAR).
  - default LANES, DATA_W and DEPTH constants.
  - function lane_match_count(mask, addrs, i).
- Sub-module histo_lane_merge: purely combinational; maps mask and addresses to per-lane write-enable and count. Keeps the collision logic unit-testable on its own.

Test Plan:
- Distinct addresses 0..7, mask=0xFF, one beat -> two cycles later rd_addr=0..7 reads 1 in every lane.
- All 8 lanes at addr 5, mask=0xFF, 3 beats back-to-back -> RAM[5]=24; in_ready held 1 throughout.
- Lanes {2,2,2,9,9,off,off,off}, mask=0x1F -> RAM[2]+=3, RAM[9]+=2; masked lanes have no effect.
- Preload RAM[7]=0xFFFE, one beat with 3 lanes at 7:
  - With HISTO_SAT_EN -> RAM[7]=0xFFFF, sat_flag=1.
  - Without it -> RAM[7]=0x0001, sat_flag=0.
- clear_start with concurrent in_valid, DEPTH=256, LANES=8:
  - The beat is counted, then cleared.
  - busy is high for 33 cycles (DRAIN plus 32 CLEAR); clear_done pulses once.
  - Afterwards all bins read 0.
- reset asserted on CLEAR cycle 10 -> next cycle IDLE, busy=0; bins 0..79 read 0, bin 80 keeps its prior value.
